// File: rtl/rx_tx_pkg.sv
// Shared link-layer constants for the RX deframer and TX framer.
// K-characters, payload type tags and the RX state encoding.
package rx_tx_pkg;

  localparam logic [7:0] K_COMMA = 8'hBC;
  localparam logic [7:0] K_SOF   = 8'hFB;
  localparam logic [7:0] K_EOF   = 8'hFD;

  localparam logic [1:0] TYPE_MID    = 2'b00;
  localparam logic [1:0] TYPE_FIRST  = 2'b01;
  localparam logic [1:0] TYPE_LAST   = 2'b10;
  localparam logic [1:0] TYPE_SINGLE = 2'b11;

  typedef enum logic [1:0] {
    LINK_DOWN,
    IDLE,
    IN_FRAME,
    DROP
  } rx_state_t;

  function automatic logic [1:0] frame_tag(
    input logic first,
    input logic last
  );
    logic [1:0] tag;
    if (first && last)
      tag = TYPE_SINGLE;
    else if (first)
      tag = TYPE_FIRST;
    else if (last)
      tag = TYPE_LAST;
    else
      tag = TYPE_MID;
    return tag;
  endfunction

endpackage

// File: rtl/rx_deframer_if.sv
// RX symbol stream plus user read port of the deframer.
// slave is the deframer side, master the PHY/user side.
interface rx_deframer_if;

  logic [7:0] rx_data;
  logic       rx_k;
  logic       rx_valid;
  logic       rx_err;
  logic       re;
  logic [7:0] dout;
  logic [1:0] dtout;
  logic       readable;

  modport master (
    output rx_data,
    output rx_k,
    output rx_valid,
    output rx_err,
    output re,
    input  dout,
    input  dtout,
    input  readable
  );

  modport slave (
    input  rx_data,
    input  rx_k,
    input  rx_valid,
    input  rx_err,
    input  re,
    output dout,
    output dtout,
    output readable
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with full/empty flags.
// Write while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_rd;
  logic             do_wr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  // Head is forced to zero when empty so outputs are clean after reset.
  assign rd_data = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_wr)
        wptr <= wptr + ONE;
      if (do_rd)
        rptr <= rptr + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr)
      mem[wptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/rx_deframer.sv
// Receive deframer: comma alignment, SOF/EOF stripping, type tagging
// and a FWFT output FIFO read through the user port.
module rx_deframer
  import rx_tx_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int ALIGN_COUNT = 8,
  parameter int ERR_LIMIT   = 4
) (
  input  logic          read_clk,
  input  logic          rst_n,
  rx_deframer_if.slave  bus,
  output logic          link_ready,
  output logic          frame_err,
  output logic          overflow
);

  localparam int AC_W = $clog2(ALIGN_COUNT + 1);
  localparam int EC_W = $clog2(ERR_LIMIT + 1);
  localparam logic [AC_W-1:0] AC_ONE = 1;
  localparam logic [EC_W-1:0] EC_ONE = 1;
  localparam logic [AC_W-1:0] AC_LAST = AC_W'(ALIGN_COUNT - 1);
  localparam logic [EC_W-1:0] EC_LAST = EC_W'(ERR_LIMIT - 1);

  rx_state_t       state;
  logic [AC_W-1:0] align_cnt;
  logic [EC_W-1:0] err_cnt;
  logic [7:0]      hold;
  logic            hold_v;
  logic            first;

  logic       clean;
  logic       sym_data;
  logic       sym_comma;
  logic       sym_sof;
  logic       sym_eof;
  logic       sym_badk;
  logic       err_hit;
  logic       err_abort;
  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;
  logic       can_push;
  logic       push_req;
  logic       fifo_wr;
  logic [9:0] push_word;
  logic [9:0] head;

  assign clean     = bus.rx_valid && !bus.rx_err;
  assign sym_data  = clean && !bus.rx_k;
  assign sym_comma = clean && bus.rx_k && (bus.rx_data == K_COMMA);
  assign sym_sof   = clean && bus.rx_k && (bus.rx_data == K_SOF);
  assign sym_eof   = clean && bus.rx_k && (bus.rx_data == K_EOF);
  assign sym_badk  = clean && bus.rx_k &&
                     !(sym_comma || sym_sof || sym_eof);

  assign err_hit   = bus.rx_valid && bus.rx_err &&
                     (state != LINK_DOWN) && (err_cnt == EC_LAST);
  assign err_abort = bus.rx_valid && bus.rx_err && !err_hit;

  // A pop in the same cycle frees the slot a full FIFO needs.
  assign pop       = bus.re && !fifo_empty;
  assign can_push  = !fifo_full || pop;
  assign push_req  = (state == IN_FRAME) && hold_v &&
                     (sym_data || sym_eof);
  assign push_word = {frame_tag(first, sym_eof), hold};
  assign fifo_wr   = push_req && can_push;

  sync_fifo #(
    .WIDTH (10),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (read_clk),
    .rst_n   (rst_n),
    .wr_en   (fifo_wr),
    .wr_data (push_word),
    .rd_en   (bus.re),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign bus.dout     = head[7:0];
  assign bus.dtout    = head[9:8];
  assign bus.readable = !fifo_empty;

  always_ff @(posedge read_clk) begin
    if (!rst_n) begin
      state      <= LINK_DOWN;
      align_cnt  <= '0;
      err_cnt    <= '0;
      hold       <= '0;
      hold_v     <= 1'b0;
      first      <= 1'b0;
      link_ready <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
      if (bus.rx_valid) begin
        if (err_hit) begin
          state      <= LINK_DOWN;
          link_ready <= 1'b0;
          hold_v     <= 1'b0;
          err_cnt    <= '0;
          align_cnt  <= '0;
          if (state == IN_FRAME)
            frame_err <= 1'b1;
        end else begin
          if (state != LINK_DOWN)
            err_cnt <= bus.rx_err ? err_cnt + EC_ONE : '0;
          case (state)
            LINK_DOWN: begin
              if (sym_comma) begin
                if (align_cnt == AC_LAST) begin
                  state      <= IDLE;
                  link_ready <= 1'b1;
                  align_cnt  <= '0;
                  err_cnt    <= '0;
                end else begin
                  align_cnt <= align_cnt + AC_ONE;
                end
              end else begin
                align_cnt <= '0;
              end
            end
            IDLE: begin
              if (sym_sof) begin
                state  <= IN_FRAME;
                first  <= 1'b1;
                hold_v <= 1'b0;
              end
            end
            IN_FRAME: begin
              unique case (1'b1)
                err_abort: begin
                  frame_err <= 1'b1;
                  hold_v    <= 1'b0;
                  state     <= IDLE;
                end
                sym_data: begin
                  if (push_req && !can_push) begin
                    overflow <= 1'b1;
                    hold_v   <= 1'b0;
                    state    <= DROP;
                  end else begin
                    if (hold_v)
                      first <= 1'b0;
                    hold   <= bus.rx_data;
                    hold_v <= 1'b1;
                  end
                end
                sym_eof: begin
                  if (!hold_v)
                    frame_err <= 1'b1;
                  else if (!can_push)
                    overflow <= 1'b1;
                  hold_v <= 1'b0;
                  state  <= IDLE;
                end
                sym_comma: begin
                end
                sym_sof: begin
                  frame_err <= 1'b1;
                  hold_v    <= 1'b0;
                  first     <= 1'b1;
                end
                sym_badk: begin
                  frame_err <= 1'b1;
                  hold_v    <= 1'b0;
                  state     <= IDLE;
                end
                default: begin
                end
              endcase
            end
            DROP: begin
              if (sym_eof) begin
                state <= IDLE;
              end else if (sym_sof) begin
                state  <= IN_FRAME;
                first  <= 1'b1;
                hold_v <= 1'b0;
              end
            end
            default: state <= LINK_DOWN;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_deframer.sv
// Scenario bench for rx_deframer with a 4-entry FIFO.
// Expected FIFO words are queued as stimulus is driven.
module tb_rx_deframer;
  import rx_tx_pkg::*;

  logic read_clk = 1'b0;
  logic rst_n = 1'b0;
  logic link_ready;
  logic frame_err;
  logic overflow;

  rx_deframer_if bus();

  rx_deframer #(
    .DEPTH       (4),
    .ALIGN_COUNT (8),
    .ERR_LIMIT   (4)
  ) dut (
    .read_clk   (read_clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .link_ready (link_ready),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  always #5 read_clk = ~read_clk;

  int total = 0;
  int bad = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [9:0] q[$];

  always @(negedge read_clk) begin
    if (frame_err) fe_cnt++;
    if (overflow) ov_cnt++;
  end

  task automatic sym(input bit k, input logic [7:0] d,
                     input bit e = 1'b0);
    @(posedge read_clk);
    #1;
    bus.rx_valid = 1'b1;
    bus.rx_k = k;
    bus.rx_data = d;
    bus.rx_err = e;
  endtask

  task automatic gap();
    @(posedge read_clk);
    #1;
    bus.rx_valid = 1'b0;
    bus.rx_k = 1'b0;
    bus.rx_err = 1'b0;
  endtask

  task automatic pop(output logic [9:0] got, output bit ok);
    ok = 1'b0;
    got = 'x;
    for (int i = 0; i < 20; i++) begin
      @(negedge read_clk);
      if (bus.readable) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      got = {bus.dtout, bus.dout};
      @(posedge read_clk);
      #1 bus.re = 1'b1;
      @(posedge read_clk);
      #1 bus.re = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge read_clk);
    @(negedge read_clk);
    total++;
    if (bus.readable !== 1'b0) begin
      bad++; $display("FAIL rst_readable got=%b want=0", bus.readable);
    end
    total++;
    if (link_ready !== 1'b0) begin
      bad++; $display("FAIL rst_link got=%b want=0", link_ready);
    end
    total++;
    if (frame_err !== 1'b0) begin
      bad++; $display("FAIL rst_ferr got=%b want=0", frame_err);
    end
    total++;
    if (overflow !== 1'b0) begin
      bad++; $display("FAIL rst_ovf got=%b want=0", overflow);
    end
    total++;
    if (bus.dout !== 8'h00) begin
      bad++; $display("FAIL rst_dout got=%h want=00", bus.dout);
    end
    total++;
    if (bus.dtout !== 2'b00) begin
      bad++; $display("FAIL rst_dtout got=%b want=00", bus.dtout);
    end
    @(posedge read_clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_align();
    repeat (7) sym(1'b1, K_COMMA);
    sym(1'b0, 8'h00);
    repeat (7) sym(1'b1, K_COMMA);
    gap();
    @(negedge read_clk);
    total++;
    if (link_ready !== 1'b0) begin
      bad++; $display("FAIL align_7 got=%b want=0", link_ready);
    end
    sym(1'b1, K_COMMA);
    gap();
    @(negedge read_clk);
    total++;
    if (link_ready !== 1'b1) begin
      bad++; $display("FAIL align_8 got=%b want=1", link_ready);
    end
  endtask

  task automatic test_normal();
    logic [9:0] got;
    logic [9:0] exp;
    bit ok;
    int fe0 = fe_cnt;
    sym(1'b1, K_SOF);
    sym(1'b0, 8'h1A);
    sym(1'b0, 8'h1B);
    q.push_back({TYPE_FIRST, 8'h1A});
    @(negedge read_clk);
    total++;
    if (bus.readable !== 1'b0) begin
      bad++; $display("FAIL lat_hold got=%b want=0", bus.readable);
    end
    sym(1'b0, 8'h1C);
    q.push_back({TYPE_MID, 8'h1B});
    @(negedge read_clk);
    total++;
    if ({bus.readable, bus.dtout, bus.dout} !== {1'b1, TYPE_FIRST, 8'h1A}) begin
      bad++;
      $display("FAIL lat_push got=%b/%h want=1/%h",
               bus.readable, {bus.dtout, bus.dout}, {TYPE_FIRST, 8'h1A});
    end
    sym(1'b1, K_EOF);
    q.push_back({TYPE_LAST, 8'h1C});
    gap();
    while (q.size() > 0) begin
      pop(got, ok);
      exp = q.pop_front();
      total++;
      if (!ok || got !== exp) begin
        bad++; $display("FAIL normal_pop got=%h ok=%0d want=%h", got, ok, exp);
      end
    end
    @(negedge read_clk);
    total++;
    if (bus.readable !== 1'b0) begin
      bad++; $display("FAIL normal_empty got=%b want=0", bus.readable);
    end
    total++;
    if (fe_cnt !== fe0) begin
      bad++; $display("FAIL normal_ferr got=%0d want=%0d", fe_cnt - fe0, 0);
    end
  endtask

  task automatic test_single_empty();
    logic [9:0] got;
    logic [9:0] exp;
    bit ok;
    int fe0 = fe_cnt;
    sym(1'b1, K_SOF);
    sym(1'b0, 8'h2C);
    sym(1'b1, K_EOF);
    q.push_back({TYPE_SINGLE, 8'h2C});
    sym(1'b1, K_SOF);
    sym(1'b1, K_EOF);
    gap();
    repeat (2) @(negedge read_clk);
    total++;
    if (fe_cnt - fe0 !== 1) begin
      bad++; $display("FAIL empty_ferr got=%0d want=1", fe_cnt - fe0);
    end
    while (q.size() > 0) begin
      pop(got, ok);
      exp = q.pop_front();
      total++;
      if (!ok || got !== exp) begin
        bad++; $display("FAIL single_pop got=%h ok=%0d want=%h", got, ok, exp);
      end
    end
    @(negedge read_clk);
    total++;
    if (bus.readable !== 1'b0) begin
      bad++; $display("FAIL single_empty got=%b want=0", bus.readable);
    end
  endtask

  task automatic test_abort();
    logic [9:0] got;
    logic [9:0] exp;
    bit ok;
    int fe0 = fe_cnt;
    sym(1'b1, K_SOF);
    sym(1'b0, 8'hAA);
    sym(1'b0, 8'h1A);
    q.push_back({TYPE_FIRST, 8'hAA});
    sym(1'b1, K_SOF);
    sym(1'b0, 8'h2B);
    sym(1'b1, K_EOF);
    q.push_back({TYPE_SINGLE, 8'h2B});
    gap();
    repeat (2) @(negedge read_clk);
    total++;
    if (fe_cnt - fe0 !== 1) begin
      bad++; $display("FAIL abort_ferr got=%0d want=1", fe_cnt - fe0);
    end
    while (q.size() > 0) begin
      pop(got, ok);
      exp = q.pop_front();
      total++;
      if (!ok || got !== exp) begin
        bad++; $display("FAIL abort_pop got=%h ok=%0d want=%h", got, ok, exp);
      end
    end
  endtask

  task automatic test_overflow();
    logic [9:0] got;
    logic [9:0] exp;
    logic [7:0] b;
    bit ok;
    int fe0 = fe_cnt;
    int ov0 = ov_cnt;
    sym(1'b1, K_SOF);
    for (int i = 0; i < 7; i++) begin
      b = 8'(8'h10 + i);
      sym(1'b0, b);
      if (i < 4)
        q.push_back({(i == 0) ? TYPE_FIRST : TYPE_MID, b});
    end
    sym(1'b1, K_EOF);
    gap();
    repeat (2) @(negedge read_clk);
    total++;
    if (ov_cnt - ov0 !== 1) begin
      bad++; $display("FAIL ovf_pulse got=%0d want=1", ov_cnt - ov0);
    end
    total++;
    if (fe_cnt - fe0 !== 0) begin
      bad++; $display("FAIL ovf_ferr got=%0d want=0", fe_cnt - fe0);
    end
    while (q.size() > 0) begin
      pop(got, ok);
      exp = q.pop_front();
      total++;
      if (!ok || got !== exp) begin
        bad++; $display("FAIL ovf_pop got=%h ok=%0d want=%h", got, ok, exp);
      end
    end
    @(negedge read_clk);
    total++;
    if (bus.readable !== 1'b0) begin
      bad++; $display("FAIL ovf_empty got=%b want=0", bus.readable);
    end
    sym(1'b1, K_SOF);
    sym(1'b0, 8'h55);
    sym(1'b1, K_EOF);
    q.push_back({TYPE_SINGLE, 8'h55});
    gap();
    while (q.size() > 0) begin
      pop(got, ok);
      exp = q.pop_front();
      total++;
      if (!ok || got !== exp) begin
        bad++; $display("FAIL ovf_next got=%h ok=%0d want=%h", got, ok, exp);
      end
    end
  endtask

  task automatic test_link_loss();
    int fe0 = fe_cnt;
    sym(1'b1, K_SOF);
    sym(1'b0, 8'h31);
    sym(1'b0, 8'h32);
    q.push_back({TYPE_FIRST, 8'h31});
    repeat (4) sym(1'b0, 8'h00, 1'b1);
    gap();
    @(negedge read_clk);
    total++;
    if (link_ready !== 1'b0) begin
      bad++; $display("FAIL loss_link got=%b want=0", link_ready);
    end
    total++;
    if ({bus.readable, bus.dtout, bus.dout} !== {1'b1, q[0]}) begin
      bad++;
      $display("FAIL loss_fifo got=%b/%h want=1/%h",
               bus.readable, {bus.dtout, bus.dout}, q[0]);
    end
    repeat (2) @(negedge read_clk);
    total++;
    if (fe_cnt - fe0 !== 1) begin
      bad++; $display("FAIL loss_ferr got=%0d want=1", fe_cnt - fe0);
    end
    @(posedge read_clk);
    #1 rst_n = 1'b0;
    @(posedge read_clk);
    #1 rst_n = 1'b1;
    q.delete();
    @(negedge read_clk);
    total++;
    if (bus.readable !== 1'b0) begin
      bad++; $display("FAIL rst2_readable got=%b want=0", bus.readable);
    end
    total++;
    if (link_ready !== 1'b0) begin
      bad++; $display("FAIL rst2_link got=%b want=0", link_ready);
    end
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_k = 1'b0;
    bus.rx_err = 1'b0;
    bus.rx_data = 8'h00;
    bus.re = 1'b0;
    test_reset();
    test_align();
    test_normal();
    test_single_empty();
    test_abort();
    test_overflow();
    test_link_loss();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_deframer.md
Name: rx_deframer

Overview:
- Receive-side counterpart of the transmit framer.
- Consumes 8b/10b-decoded bytes from the GTP RX path and tracks comma alignment to drive link_ready.
- Strips SOF/EOF K-characters and re-tags payload bytes with the same 2-bit type code the write side accepts (01 first, 00 middle, 10 last, 11 single-byte frame).
- Buffers tagged bytes in a small FIFO drained by the user read port (re/readable) in the read_clk domain.

Parameters:
- DEPTH, 16, output FIFO entries (power of 2, >=4).
- ALIGN_COUNT, 8, consecutive K28.5 commas required to declare link up.
- ERR_LIMIT, 4, consecutive code/disparity errors that drop the link.
- K_COMMA, 8'hBC, idle/comma symbol (K28.5).
- K_SOF, 8'hFB, start-of-frame symbol (K27.7).
- K_EOF, 8'hFD, end-of-frame symbol (K29.7).

Ports:
- read_clk  in  1  sole clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- rx_data  in  8  decoded RX byte.
- rx_k  in  1  rx_data is a K-character.
- rx_valid  in  1  rx_data/rx_k/rx_err valid this cycle.
- rx_err  in  1  8b/10b code or disparity error on this symbol.
- re  in  1  read enable; pops head when readable=1.
- dout  out  8  FIFO head payload byte.
- dtout  out  2  FIFO head type tag.
- readable  out  1  FIFO non-empty.
- link_ready  out  1  alignment achieved.
- frame_err  out  1  one-cycle pulse: frame aborted (bad K-char in frame, rx_err in frame, empty frame).
- overflow  out  1  one-cycle pulse: byte lost to full FIFO.

Behaviour:
- Clock/reset: one clock, read_clk. Reset is synchronous, active-low on rst_n.
- On reset: FSM=LINK_DOWN, FIFO empty, hold register empty, counters 0; readable, link_ready, frame_err, overflow = 0; dout/dtout = 0.
- Only cycles with rx_valid=1 advance the FSM or counters.
- FSM states: LINK_DOWN, IDLE, IN_FRAME, DROP.
- LINK_DOWN:
  - Count consecutive K_COMMA symbols; any other symbol resets the count to 0.
  - At count==ALIGN_COUNT: go to IDLE; link_ready=1 from the next cycle.
- Error counter (all states except LINK_DOWN):
  - rx_err increments the consecutive-error counter; any clean symbol clears it.
  - At ERR_LIMIT: go to LINK_DOWN, link_ready=0, hold register cleared.
  - If this happens in IN_FRAME, pulse frame_err. FIFO contents are retained.
- IDLE:
  - K_SOF -> IN_FRAME with first=1, hold empty.
  - K_COMMA and data bytes outside a frame are ignored.
  - K_EOF in IDLE is ignored.
- IN_FRAME:
  - Data byte: if hold is full, push the held byte with tag first?01:00 and clear first. Then load the new byte into hold.
  - K_EOF, hold full: push the held byte with tag first?11:10, then go to IDLE.
  - K_EOF, hold empty (empty frame): pulse frame_err, go to IDLE.
  - K_COMMA inside a frame is ignored (idle fill permitted).
  - K_SOF or any other K, or rx_err: discard hold and pulse frame_err. Next state is IN_FRAME (fresh, first=1) if the symbol was K_SOF, otherwise IDLE.
- Push/overflow:
  - At most one push per cycle. Push latency: byte visible at dout one cycle after the symbol that commits it.
  - A payload byte therefore appears at dout 2 valid symbols later, or 1 cycle after EOF for the last byte.
  - Push while full: byte dropped, pulse overflow, go to DROP.
- DROP:
  - Discard everything until K_EOF (-> IDLE) or K_SOF (-> IN_FRAME fresh).
  - No further overflow pulses are generated in DROP.
- FIFO read side:
  - First-word-fall-through: dout/dtout show the head whenever readable=1.
  - re=1 with readable=0 is ignored.
  - Simultaneous push and pop when full is allowed: no overflow, occupancy unchanged.
  - Pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full when the MSBs differ and the remaining bits are equal.
- Error pulses: frame_err and overflow are registered, high exactly one cycle per event; both may assert in the same cycle.
- Reset mid-frame: the partial frame is discarded and the FIFO is flushed.

Decomposition:
- Shared package rx_tx_pkg holds:
  - K_COMMA, K_SOF, K_EOF;
  - type codes TYPE_MID=2'b00, TYPE_FIRST=2'b01, TYPE_LAST=2'b10, TYPE_SINGLE=2'b11;
  - the FSM state enum.
- The transmit framer reuses the same package.
- One sub-module: sync_fifo (width 10 = {dtout, dout}, DEPTH, FWFT, full/empty flags). It is shared with future same-clock buffers.

Test Plan:
- Alignment: 7 commas then a data byte, then 8 commas -> link_ready stays 0 after the 7, rises the cycle after the 8th comma.
- Normal frame: SOF,1A,1B,1C,EOF -> FIFO holds (01,1A),(00,1B),(10,1C). re drains them in order; readable falls after the 3rd pop.
- Single and empty frames: SOF,2C,EOF -> (11,2C). SOF,EOF -> nothing pushed, frame_err one pulse.
- Abort: SOF,AA,1A, then SOF,2B,EOF -> (01,AA) pushed, 1A discarded, one frame_err pulse, then (11,2B).
- Overflow with DEPTH=4, re=0: frame of 7 bytes -> 4 entries stored, one overflow pulse, rest dropped. The next frame SOF,55,EOF is accepted after reads free space.
- Link loss: 4 consecutive rx_err mid-frame -> link_ready=0, one frame_err pulse, FIFO contents intact. rst_n=0 for one cycle -> readable=0, link_ready=0.
